// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply-divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with stall handshake.
module execute_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] acc_q;     // product high half, or partial remainder
  logic [XLEN-1:0] lo_q;      // product low half / multiplier, or quotient
  logic [XLEN-1:0] opb_q;     // multiplicand, or divisor
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic [XLEN-1:0] result_q;

  // Operand conditioning at capture time
  logic            is_div_d, signed_a_d, signed_b_d, neg_a_d, neg_b_d;
  logic [XLEN-1:0] mag_a_d, mag_b_d;
  logic            div_zero_d, div_ovf_d;
  logic [XLEN-1:0] special_res_d;

  always_comb begin
    is_div_d   = md_op_i[2];
    signed_a_d = (md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) ||
                 (md_op_i == OP_DIV)  || (md_op_i == OP_REM);
    signed_b_d = (md_op_i == OP_MULH) || (md_op_i == OP_DIV) || (md_op_i == OP_REM);
    neg_a_d    = signed_a_d & operand_a_i[XLEN-1];
    neg_b_d    = signed_b_d & operand_b_i[XLEN-1];
    mag_a_d    = neg_a_d ? -operand_a_i : operand_a_i;
    mag_b_d    = neg_b_d ? -operand_b_i : operand_b_i;
    div_zero_d = is_div_d && (operand_b_i == '0);
    div_ovf_d  = ((md_op_i == OP_DIV) || (md_op_i == OP_REM)) &&
                 (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b_i == '1);
    special_res_d = '0;
    if (div_zero_d)
      special_res_d = md_op_i[1] ? operand_a_i : '1;
    else if (div_ovf_d)
      special_res_d = md_op_i[1] ? '0 : operand_a_i;
  end

  // One iteration of both algorithms; op_q[2] selects which one is kept
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, rem_n, quot_n;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_n, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

    rem_sh = {acc_q, lo_q[XLEN-1]};
    div_ge = rem_sh >= {1'b0, opb_q};
    rem_n  = div_ge ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
    quot_n = {lo_q[XLEN-2:0], div_ge};

    prod_n   = {mul_hi_n, mul_lo_n};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_n : prod_n;
    quot_fix = (sign_a_q ^ sign_b_q) ? -quot_n : quot_n;
    rem_fix  = sign_a_q ? -rem_n : rem_n;

    unique case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q     <= md_op_i;
            sign_a_q <= neg_a_d;
            sign_b_q <= neg_b_d;
            acc_q    <= '0;
            lo_q     <= is_div_d ? mag_a_d : mag_b_d;
            opb_q    <= is_div_d ? mag_b_d : mag_a_d;
            count_q  <= CW'(XLEN - 1);
            busy_q   <= 1'b1;
            if (div_zero_d || div_ovf_d) begin
              result_q <= special_res_d;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          acc_q   <= op_q[2] ? rem_n  : mul_hi_n;
          lo_q    <= op_q[2] ? quot_n : mul_lo_n;
          count_q <= count_q - 1'b1;
          // Sign correction is folded into the final step so result_o is ready in DONE
          if (count_q == '0) begin
            result_q <= final_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done_o   = (state_q == DONE) & ~flush_i;
  assign busy_o   = busy_q;
  assign stall_o  = valid_i & ~done_o & ~flush_i;
  assign result_o = result_q;

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M/RV64M multiply-divide unit that sits beside the ALU in the execute stage. It accepts already-forwarded operands and funct3 from the EX stage and computes the result over multiple cycles, shift-add for multiplies and restoring division for divides. While it works it holds the pipeline with a stall request. On completion it presents the XLEN-bit result for one cycle, and the EX/MEM register captures it together with the rest of the instruction.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_i  input  1  EX holds an M-extension op; held stable with operands until done_o.
- md_op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_i  input  XLEN  rs1 value after forwarding.
- operand_b_i  input  XLEN  rs2 value after forwarding.
- flush_i  input  1  kill the in-flight op (branch/jump redirect, exception).
- stall_o  output  1  combinational stall request to the hazard unit.
- busy_o  output  1  registered; high in CALC and DONE.
- done_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  XLEN  result; meaningful only when done_o=1.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **IDLE**, with valid_i=1 and flush_i=0:
  - Latch md_op, the operand signs and the operands.
  - Signed ops use magnitudes: signed-signed for MULH, DIV and REM; a signed and b unsigned for MULHSU.
  - MUL uses unsigned magnitudes of both operands. The low half is sign-independent.
  - Load count = XLEN-1 and go to CALC.
- **Special cases in IDLE** go straight to DONE with the result preloaded and no CALC:
  - Divide by zero (b=0): DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (DIV/REM, a = most negative, b = all ones): DIV gives a; REM gives 0.
- **CALC, multiply**:
  - Uses a 2*XLEN-bit product register {hi,lo} plus a carry bit; lo is initialised to the multiplier magnitude.
  - Each cycle: if lo[0], hi += multiplicand with carry-out. Then shift {carry,hi,lo} right by 1.
- **CALC, divide**:
  - Remainder register is XLEN+1 bits; the quotient register is initialised to the dividend magnitude.
  - Each cycle: rem = {rem[XLEN-1:0], quot[XLEN-1]}, quot <<= 1.
  - If rem >= divisor: rem -= divisor and quot[0] = 1.
- **CALC exit**: count decrements each cycle; when count = 0, go to DONE.
- **DONE**:
  - Sign-correct. MULH/MULHSU negate the full 2*XLEN product if the signs differ. DIV negates the quotient if the signs differ. REM takes the sign of the dividend.
  - Select the output: MUL gives the low half; MULH, MULHSU and MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register the result into result_o, assert done_o, and return to IDLE.
- **stall_o** = valid_i & ~done_o & ~flush_i.
- **Flush**: flush_i=1 in any state returns the FSM to IDLE on the next edge. done_o is gated low in that cycle, and no result is produced for the killed op.
- **Reset**:
  - FSM goes to IDLE and count to 0.
  - stall_o follows its equation.
  - done_o=0, busy_o=0, result_o=0 and all datapath registers are 0.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). Negation is two's complement.

## Timing
- Normal op latency: valid_i rises at cycle 0 (IDLE capture), CALC runs cycles 1..XLEN, and done_o=1 at cycle XLEN+1. That is 34 cycles for XLEN=32 and 66 for XLEN=64.
- Special cases: done_o=1 at cycle 1.
- In the done_o cycle stall_o=0, so the pipeline advances and EX/MEM captures result_o on that edge.
- The FSM is in IDLE the next cycle. If valid_i is still high there (a new M-op now in EX), capture starts immediately with no bubble.
- result_o holds its value after done_o until the next DONE; consumers must use it only with done_o.
- Flush and done in the same cycle: flush wins, and done_o=0.
- Flush and valid_i in IDLE: no capture.
- Reset overrides flush and valid_i.

## Test plan
- MUL a=7, b=0xFFFFFFFD (XLEN=32) -> done_o at cycle 33 with result_o=0xFFFFFFEB; stall_o high for cycles 0..32.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 0x00000007, each with done_o at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Flush at CALC cycle 10 -> no done_o, busy_o=0 next cycle. A following MUL 3x5 then completes with 15 at full latency. Flush coincident with the DONE cycle -> done_o stays 0.
- XLEN=64: MULHU all-ones x all-ones -> 0xFFFFFFFFFFFFFFFE at cycle 65. Back-to-back DIVU 100/7 then REMU 100/7 -> 14 then 2, with no idle cycle between them.
